match_req_dispatch: RTL and testbench
=====================================

# match_req_dispatch

Issue side of the per-job-PE match protocol. Accepts one request group of up to L lazy-match slots from a job PE. Spreads the strobed slots as tagged requests over C match-request channels. Holds off the next group until the response collector reports the complete response group. It also drives the group fire/strobe pair that arms the response collector.

## Interface
Parameters:
- JOB_PE_IDX, 0, index of owning job PE (debug logging only)
- L, `LAZY_LEN, slots per request group
- C, `NUM_MATCH_REQ_CH, match-request channels
- TAG_BITS, `LAZY_LEN_LOG2, slot tag width
- AW, `ADDR_WIDTH, per-slot match candidate address width

Ports:
- clk  in  1  clock, single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- job_req_valid  in  1  request group offered by job PE
- job_req_ready  out  1  group accepted when valid & ready
- job_req_strb  in  L  bit i set = slot i needs a match
- job_req_addr  in  L*AW  slot i address at [i*AW +: AW]
- req_group_fire  out  1  one-cycle pulse, = job_req_valid & job_req_ready
- req_group_strb  out  L  = job_req_strb; meaningful only while req_group_fire = 1
- req_valid  out  C  per-channel request valid
- req_ready  in  C  per-channel request ready
- req_tag  out  C*TAG_BITS  slot index carried by channel j
- req_addr  out  C*AW  slot address carried by channel j
- resp_group_fire  in  1  collector handed the complete response group to the job PE

## Operation
Internal state:
- addr_reg: L*AW, captured at group accept
- pend: L bits, set = slot not yet handed to any channel
- Per channel j: ch_vld[j], ch_tag[j]

States:
- IDLE. job_req_ready = 1. On accept: addr_reg <= job_req_addr and the initial allocation runs on job_req_strb. Next state is ISSUE. An all-zero strobe goes directly to WAIT.
- ISSUE. job_req_ready = 0. Move to WAIT at the edge where pend becomes 0 and no ch_vld remains set after that edge's handshakes.
- WAIT. job_req_ready = 0, all req_valid = 0. On resp_group_fire, go to IDLE.

Allocation, evaluated at every clock edge:
- A channel is free if ch_vld[j] = 0, or if req_valid[j] & req_ready[j] in this cycle.
- Free channels are filled in ascending j with pending slots in ascending slot index.
- The pending set used is pend, or job_req_strb on the accept edge.
- Each slot goes to exactly one channel. Its pend bit clears when assigned.
- Channels left without a slot clear ch_vld.

Channel outputs:
- req_valid[j] = ch_vld[j]; req_tag[j] = ch_tag[j]; req_addr[j] = addr_reg[ch_tag[j]*AW +: AW].
- Once req_valid[j] rises, tag and addr stay stable until the handshake.
- req_valid never drops without a handshake.

Other rules:
- resp_group_fire outside WAIT is a protocol error: ignored, `JOB_PE_DEBUG_LOG reports it.
- Under `JOB_PE_DEBUG_LOG, display every group accept and every channel handshake with tag and address.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, pend = 0, ch_vld = 0, addr_reg = 0. Outputs: job_req_ready = 1, req_valid = 0, req_tag = 0, req_addr = 0, req_group_fire = 0.
- Accept in cycle T: req_group_fire high in T only. The first min(C, popcount) requests are valid in T+1.
- Per-channel throughput: one request per cycle. A handshake in cycle t is followed by the next slot in t+1 on the same channel.
- Issue duration: a group of n strobed slots with ready held high is fully issued in ceil(n/C) cycles.
- Back-pressure: a stalled channel keeps its slot. Other channels keep draining pend.
- WAIT exit: resp_group_fire in cycle t gives job_req_ready = 1 in t+1. There is no same-cycle bypass.
- Minimum gap between two req_group_fire pulses is 2 cycles.
- Reset mid-group discards all pending and in-flight slots immediately.

## Test plan
L=4, C=2 unless noted.
- Full strobe, ready=11: accept strb 1111 in T. Cycle T+1: tags (0,1). T+2: tags (2,3). T+3: req_valid = 00, in WAIT. resp_group_fire at T+5 -> job_req_ready = 1 at T+6.
- Sparse strobe 1010, addr slot1 = 0x100, slot3 = 0x300: T+1 ch0 = (tag 1, 0x100), ch1 = (tag 3, 0x300). req_group_strb = 1010 during fire only.
- Back-pressure: strb 1111, req_ready[0] held 0 for 3 cycles. Ch0 holds tag 0 stable. Ch1 issues 1, 2, 3 in consecutive cycles. WAIT entered only after ch0 handshakes.
- Zero strobe: strb 0000 -> fire pulse, no req_valid. Stays in WAIT until resp_group_fire, then IDLE.
- Reset: rst_n low while ch0 and ch1 are valid -> req_valid = 00 and job_req_ready = 1 during reset, without waiting for a clock edge. The next group issues from tag 0.
- C=4, L=4, strb 0111: all three issued in T+1 on ch0..ch2 with tags 0, 1, 2. ch3 stays idle.

Source files
------------

// File: rtl/match_req_dispatch.sv
// Issue side of the per-job-PE match protocol: accepts one request group of
// L lazy-match slots and spreads the strobed slots over C tagged channels.
module match_req_dispatch #(
  parameter int unsigned JOB_PE_IDX = 0,
  parameter int unsigned L          = 4,
  parameter int unsigned C          = 2,
  parameter int unsigned TAG_BITS   = 2,
  parameter int unsigned AW         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_req_valid,
  output logic                  job_req_ready,
  input  logic [L-1:0]          job_req_strb,
  input  logic [L*AW-1:0]       job_req_addr,
  output logic                  req_group_fire,
  output logic [L-1:0]          req_group_strb,
  output logic [C-1:0]          req_valid,
  input  logic [C-1:0]          req_ready,
  output logic [C*TAG_BITS-1:0] req_tag,
  output logic [C*AW-1:0]       req_addr,
  input  logic                  resp_group_fire
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [L*AW-1:0]     addr_reg, addr_n;
  logic [L-1:0]        pend, pend_n, pool;
  logic [C-1:0]        ch_vld, vld_n;
  logic [TAG_BITS-1:0] ch_tag [C];
  logic [TAG_BITS-1:0] tag_n  [C];
  logic                accept_c;
  logic                found;

  assign job_req_ready  = (state == IDLE);
  assign accept_c       = job_req_valid & job_req_ready;
  assign req_group_fire = accept_c;
  assign req_group_strb = job_req_strb;
  assign req_valid      = ch_vld;

  // Each channel presents its held tag and the captured address of that slot
  always_comb begin
    req_tag  = '0;
    req_addr = '0;
    for (int j = 0; j < int'(C); j++) begin
      req_tag[j*TAG_BITS +: TAG_BITS] = ch_tag[j];
      req_addr[j*AW +: AW]            = addr_reg[int'(ch_tag[j])*AW +: AW];
    end
  end

  // Allocation and next state: free channels take the lowest pending slots
  always_comb begin
    state_n = state;
    addr_n  = addr_reg;
    vld_n   = ch_vld;
    tag_n   = ch_tag;
    pool    = accept_c ? job_req_strb : pend;
    found   = 1'b0;

    if (accept_c) addr_n = job_req_addr;

    for (int j = 0; j < int'(C); j++) begin
      if (!ch_vld[j] || req_ready[j]) begin
        vld_n[j] = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < int'(L); i++) begin
          if (!found && pool[i]) begin
            found    = 1'b1;
            pool[i]  = 1'b0;
            vld_n[j] = 1'b1;
            tag_n[j] = TAG_BITS'(i);
          end
        end
      end
    end
    pend_n = pool;

    case (state)
      IDLE:    if (accept_c) state_n = (pend_n == '0 && vld_n == '0) ? WAIT : ISSUE;
      ISSUE:   if (pend_n == '0 && vld_n == '0) state_n = WAIT;
      WAIT:    if (resp_group_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_reg <= '0;
      pend     <= '0;
      ch_vld   <= '0;
      for (int j = 0; j < int'(C); j++) ch_tag[j] <= '0;
    end else begin
      state    <= state_n;
      addr_reg <= addr_n;
      pend     <= pend_n;
      ch_vld   <= vld_n;
      for (int j = 0; j < int'(C); j++) ch_tag[j] <= tag_n[j];
    end
  end

`ifdef JOB_PE_DEBUG_LOG
  always @(posedge clk) begin
    if (rst_n) begin
      if (accept_c)
        $display("job_pe %0d: group accept strb=%b", JOB_PE_IDX, job_req_strb);
      for (int j = 0; j < int'(C); j++)
        if (req_valid[j] && req_ready[j])
          $display("job_pe %0d: ch%0d tag=%0d addr=%h", JOB_PE_IDX, j,
                   ch_tag[j], req_addr[j*AW +: AW]);
      if (resp_group_fire && state != WAIT)
        $display("job_pe %0d: protocol error, resp_group_fire outside WAIT", JOB_PE_IDX);
    end
  end
`endif

endmodule

// File: tb/tb_match_req_dispatch.sv
// Directed bench for match_req_dispatch with a handshake scoreboard.
module tb_match_req_dispatch;

  localparam int unsigned L  = 4;
  localparam int unsigned C2 = 2;
  localparam int unsigned C4 = 4;
  localparam int unsigned TB = 2;
  localparam int unsigned AW = 16;

  typedef struct {
    int ch;
    int tag;
    int addr;
  } exp_t;

  logic clk, rst_n;

  logic              job_req_valid, job_req_ready, req_group_fire, resp_group_fire;
  logic [L-1:0]      job_req_strb, req_group_strb;
  logic [L*AW-1:0]   job_req_addr;
  logic [C2-1:0]     req_valid, req_ready;
  logic [C2*TB-1:0]  req_tag;
  logic [C2*AW-1:0]  req_addr;

  logic              v4, rdy4_job, fire4, resp4;
  logic [L-1:0]      strb4, gstrb4;
  logic [L*AW-1:0]   addr4;
  logic [C4-1:0]     valid4, ready4;
  logic [C4*TB-1:0]  tag4;
  logic [C4*AW-1:0]  raddr4;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  match_req_dispatch #(.JOB_PE_IDX(0), .L(L), .C(C2), .TAG_BITS(TB), .AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .job_req_valid(job_req_valid), .job_req_ready(job_req_ready),
    .job_req_strb(job_req_strb), .job_req_addr(job_req_addr),
    .req_group_fire(req_group_fire), .req_group_strb(req_group_strb),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_addr(req_addr),
    .resp_group_fire(resp_group_fire)
  );

  match_req_dispatch #(.JOB_PE_IDX(1), .L(L), .C(C4), .TAG_BITS(TB), .AW(AW)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .job_req_valid(v4), .job_req_ready(rdy4_job),
    .job_req_strb(strb4), .job_req_addr(addr4),
    .req_group_fire(fire4), .req_group_strb(gstrb4),
    .req_valid(valid4), .req_ready(ready4),
    .req_tag(tag4), .req_addr(raddr4),
    .resp_group_fire(resp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input int ch, input int tag, input int addr);
    exp_t e;
    e.ch = ch; e.tag = tag; e.addr = addr;
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] tag_of(input int j);
    return 64'(req_tag[j*TB +: TB]);
  endfunction

  function automatic logic [63:0] addr_of(input int j);
    return 64'(req_addr[j*AW +: AW]);
  endfunction

  // Scoreboard: every channel handshake pops the next expected (ch, tag, addr)
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < int'(C2); j++) begin
        if (req_valid[j] && req_ready[j]) begin
          if (exp_q.size() == 0) begin
            check("hs_unexpected", 64'(exp_q.size()), 64'(1));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("hs_ch", 64'(j), 64'(e.ch));
            check("hs_tag", tag_of(j), 64'(e.tag));
            check("hs_addr", addr_of(j), 64'(e.addr));
          end
        end
      end
    end
  end

  task automatic finish_group();
    step(); resp_group_fire = 1'b1;
    mid();  check("wait_ready_low", 64'(job_req_ready), 64'(0));
    step(); resp_group_fire = 1'b0;
    mid();  check("idle_ready", 64'(job_req_ready), 64'(1));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [L*AW-1:0] a;
    rst_n = 1'b0; job_req_valid = 1'b0; job_req_strb = '0; job_req_addr = '0;
    req_ready = '0; resp_group_fire = 1'b0;
    v4 = 1'b0; strb4 = '0; addr4 = '0; ready4 = '0; resp4 = 1'b0;

    // Reset values
    mid();
    check("rst_ready", 64'(job_req_ready), 64'(1));
    check("rst_valid", 64'(req_valid), 64'(0));
    check("rst_tag", 64'(req_tag), 64'(0));
    check("rst_addr", 64'(req_addr), 64'(0));
    check("rst_fire", 64'(req_group_fire), 64'(0));
    check("rst_valid4", 64'(valid4), 64'(0));
    step(); step(); rst_n = 1'b1;

    // Full strobe, ready held high
    a = {16'h1033, 16'h1022, 16'h1011, 16'h1000};
    step(); req_ready = 2'b11;
    job_req_valid = 1'b1; job_req_strb = 4'b1111; job_req_addr = a;
    push(0, 0, 'h1000); push(1, 1, 'h1011); push(0, 2, 'h1022); push(1, 3, 'h1033);
    mid();  check("full_fire", 64'(req_group_fire), 64'(1));
    check("full_gstrb", 64'(req_group_strb), 64'(4'b1111));
    step(); job_req_valid = 1'b0;
    mid();  check("full_t1_valid", 64'(req_valid), 64'(2'b11));
    check("full_t1_tag0", tag_of(0), 64'(0));
    check("full_t1_tag1", tag_of(1), 64'(1));
    check("full_t1_ready", 64'(job_req_ready), 64'(0));
    step(); mid();
    check("full_t2_tag0", tag_of(0), 64'(2));
    check("full_t2_tag1", tag_of(1), 64'(3));
    step(); mid();
    check("full_t3_valid", 64'(req_valid), 64'(0));
    check("full_t3_ready", 64'(job_req_ready), 64'(0));
    step();
    finish_group();

    // Sparse strobe 1010
    a = {16'h0300, 16'h0aaa, 16'h0100, 16'h0bbb};
    step(); job_req_valid = 1'b1; job_req_strb = 4'b1010; job_req_addr = a;
    push(0, 1, 'h100); push(1, 3, 'h300);
    mid();  check("sparse_gstrb", 64'(req_group_strb), 64'(4'b1010));
    check("sparse_fire", 64'(req_group_fire), 64'(1));
    step(); job_req_valid = 1'b0;
    mid();  check("sparse_fire_low", 64'(req_group_fire), 64'(0));
    check("sparse_ch0_tag", tag_of(0), 64'(1));
    check("sparse_ch0_addr", addr_of(0), 64'(16'h100));
    check("sparse_ch1_tag", tag_of(1), 64'(3));
    check("sparse_ch1_addr", addr_of(1), 64'(16'h300));
    step(); mid();
    check("sparse_done", 64'(req_valid), 64'(0));
    finish_group();

    // Back-pressure on channel 0 for three cycles
    a = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
    step(); req_ready = 2'b10;
    job_req_valid = 1'b1; job_req_strb = 4'b1111; job_req_addr = a;
    push(1, 1, 'h4001); push(1, 2, 'h4002); push(1, 3, 'h4003); push(0, 0, 'h4000);
    step(); job_req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      mid();
      check("bp_ch0_valid", 64'(req_valid[0]), 64'(1));
      check("bp_ch0_tag", tag_of(0), 64'(0));
      check("bp_ch1_tag", tag_of(1), 64'(k));
      step();
    end
    req_ready = 2'b11;
    mid();  check("bp_t4_valid", 64'(req_valid), 64'(2'b01));
    check("bp_t4_not_wait", 64'(job_req_ready), 64'(0));
    step(); mid();
    check("bp_t5_valid", 64'(req_valid), 64'(0));
    finish_group();

    // Zero strobe goes straight to WAIT
    step(); job_req_valid = 1'b1; job_req_strb = 4'b0000;
    mid();  check("zero_fire", 64'(req_group_fire), 64'(1));
    step(); job_req_valid = 1'b0;
    mid();  check("zero_valid", 64'(req_valid), 64'(0));
    check("zero_ready", 64'(job_req_ready), 64'(0));
    step(); mid();
    check("zero_hold_ready", 64'(job_req_ready), 64'(0));
    finish_group();

    // Asynchronous reset mid-group
    a = {16'h5003, 16'h5002, 16'h5001, 16'h5000};
    step(); req_ready = 2'b00;
    job_req_valid = 1'b1; job_req_strb = 4'b1111; job_req_addr = a;
    step(); job_req_valid = 1'b0;
    mid();  check("rstmid_valid_pre", 64'(req_valid), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", 64'(req_valid), 64'(0));
    check("rstmid_ready", 64'(job_req_ready), 64'(1));
    mid(); rst_n = 1'b1;
    step(); req_ready = 2'b11;
    job_req_valid = 1'b1; job_req_strb = 4'b1111; job_req_addr = a;
    push(0, 0, 'h5000); push(1, 1, 'h5001); push(0, 2, 'h5002); push(1, 3, 'h5003);
    step(); job_req_valid = 1'b0;
    mid();  check("rstmid_tag0", tag_of(0), 64'(0));
    check("rstmid_tag1", tag_of(1), 64'(1));
    step(); step();
    finish_group();

    // Four channels, strobe 0111
    step(); ready4 = 4'b1111;
    v4 = 1'b1; strb4 = 4'b0111; addr4 = {16'h7003, 16'h7002, 16'h7001, 16'h7000};
    step(); v4 = 1'b0;
    mid();
    check("c4_valid", 64'(valid4), 64'(4'b0111));
    check("c4_tag0", 64'(tag4[0 +: TB]), 64'(0));
    check("c4_tag1", 64'(tag4[TB +: TB]), 64'(1));
    check("c4_tag2", 64'(tag4[2*TB +: TB]), 64'(2));
    check("c4_addr2", 64'(raddr4[2*AW +: AW]), 64'(16'h7002));
    step(); mid();
    check("c4_done", 64'(valid4), 64'(0));
    check("c4_wait", 64'(rdy4_job), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
